reg_share_arb: RTL and testbench
================================

# reg_share_arb

Shared 32-bit holding-register controller with a valid/ready handshake. NUM_REQ producers compete for one enable-loaded 32-bit register. The block arbitrates among them, loads the winner's word into the register and presents it downstream with the winner's index. It sits between several valid/ready sources and a single valid/ready sink. It sustains one transfer per cycle when the sink is always ready.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of the source-index field

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- src_valid  input  NUM_REQ  per-requester valid
- src_data  input  NUM_REQ*32  requester i occupies bits [32*i+31:32*i]
- src_ready  output  NUM_REQ  per-requester ready; one-hot or zero
- dst_valid  output  1  holding register contains an unconsumed word
- dst_data  output  32  holding-register contents
- dst_id  output  ID_W  index of the requester whose word is held
- dst_ready  input  1  sink accepts the word

## Operation
- **Reset values:**
  - State is EMPTY.
  - The holding register, dst_id and the priority pointer are 0.
  - dst_valid is 0.
  - src_ready is all 0.
- **FSM states:** EMPTY and FULL. dst_valid = (state == FULL).
- **can_load** = EMPTY, or (FULL && dst_ready).
- **Grant:**
  - When can_load is 1 and any src_valid is 1, the arbiter selects winner w and drives src_ready[w] = 1 combinationally. All other bits are 0.
  - If can_load is 0 or no source is valid, src_ready = 0.
- **Load:**
  - On a source handshake (src_valid[w] && src_ready[w]), the register enable is asserted.
  - At the next edge the holding register gets src_data[w] and dst_id gets w.
  - The register is never written without a handshake.
- **Transitions:**
  - EMPTY with a grant → FULL.
  - EMPTY with no request → EMPTY.
  - FULL && !dst_ready → FULL. Data and id are held stable.
  - FULL && dst_ready && grant → FULL, reloaded in the same cycle (pass-through).
  - FULL && dst_ready && no request → EMPTY. Data retains its last value.
- **Arbitration** (with RR_ARB_EN, see Configuration):
  - Round-robin, searching from ptr upward and wrapping at NUM_REQ-1 → 0.
  - After a grant to w: ptr = (w+1) mod NUM_REQ. If w = NUM_REQ-1, ptr wraps to 0.
  - ptr is unchanged when there is no grant.
- **Source rule:** a requester holds valid and data stable until it sees ready. The block does not depend on this rule for correctness. It samples data only on a handshake.
- **Reset mid-operation:** asynchronous return to the reset values. A held word is discarded and is not re-presented.

## Timing
- Source handshake at edge k → dst_valid = 1, with the new dst_data/dst_id, immediately after edge k. Latency is 1 cycle.
- src_ready depends combinationally on src_valid, dst_ready and state.
- dst_valid, dst_data and dst_id are registered outputs with no combinational path from inputs.
- Throughput is 1 word per cycle while dst_ready = 1 and requests are pending.
- While stalled (dst_valid && !dst_ready): dst_data and dst_id are stable, and src_ready = 0.

## Configuration
- Macro **RR_ARB_EN**:
  - Defined: round-robin arbitration with the rotating priority pointer described above.
  - Undefined: fixed priority, where the lowest asserted index wins. The pointer register is removed, and all other behaviour is identical.

## Test plan
- **Single transfer:** reset, then src_valid = 4'b0100 with data 0xDEADBEEF on requester 2 and dst_ready = 1.
  - src_ready = 4'b0100 in that cycle.
  - Next cycle: dst_valid = 1, dst_data = 0xDEADBEEF, dst_id = 2.
  - Following cycle: dst_valid = 0.
- **Backpressure:** load 0x12345678 from requester 0, then hold dst_ready = 0 for 5 cycles while requester 1 stays valid.
  - dst_data stays 0x12345678 and src_ready stays 0 throughout.
  - One cycle after dst_ready = 1: dst_data = requester 1's word, dst_id = 1.
- **Round-robin** (RR_ARB_EN): all 4 requesters continuously valid, dst_ready = 1.
  - dst_id sequence is 0,1,2,3,0,1 on consecutive cycles.
  - No bubbles: dst_valid stays 1.
- **Fixed priority** (RR_ARB_EN undefined): same stimulus as round-robin.
  - dst_id = 0 every cycle.
  - Deasserting src_valid[0] → dst_id = 1 on the next load.
- **Reset mid-operation:** FULL with 0xCAFEF00D, then assert rst_n = 0 for one cycle mid-clock.
  - Immediately: dst_valid = 0, dst_data = 0, src_ready = 0.
  - After release: the first grant goes to the lowest-index valid requester (ptr = 0).
- **Drain to empty:** one word loaded, dst_ready = 1, no further requests.
  - dst_valid drops after one cycle.
  - dst_data retains the value.
  - A later request is accepted immediately (src_ready = 1 in the same cycle).

Source files
------------

// File: rtl/reg_share_arb.sv
// Shared 32-bit holding register with valid/ready arbitration among NUM_REQ sources.
// Optional RR_ARB_EN: round-robin arbitration (default build: fixed priority, lowest index wins).
module reg_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    src_valid,
  input  logic [NUM_REQ*32-1:0] src_data,
  output logic [NUM_REQ-1:0]    src_ready,
  output logic                  dst_valid,
  output logic [31:0]           dst_data,
  output logic [ID_W-1:0]       dst_id,
  input  logic                  dst_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  logic [31:0]       hold;
  logic [ID_W-1:0]   hold_id;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]       win_data;
  logic              can_load;
  logic              load;

`ifdef RR_ARB_EN
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   idx;

  // Round-robin search starting at ptr, wrapping at NUM_REQ-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Advance priority past the winner after every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      if (win == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else ptr <= win + 1'b1;
    end
  end
`else
  // Fixed priority: lowest asserted index wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (src_valid[k]) begin
        found = 1'b1;
        win   = ID_W'(k);
      end
    end
  end
`endif

  // Select the winning source's data word.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win) win_data = src_data[32*k +: 32];
    end
  end

  assign can_load = (state == EMPTY) || dst_ready;

  // One-hot grant, suppressed while stalled, idle or in reset.
  always_comb begin
    gnt      = '0;
    gnt[win] = 1'b1;
    if (rst_n && can_load && found) src_ready = gnt;
    else src_ready = '0;
  end

  assign load = |(src_valid & src_ready);

  // Holding-register FSM; data/id only change on a source handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      hold    <= '0;
      hold_id <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (load) begin
            state   <= FULL;
            hold    <= win_data;
            hold_id <= win;
          end
        end
        FULL: begin
          if (dst_ready) begin
            if (load) begin
              hold    <= win_data;
              hold_id <= win;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign dst_valid = (state == FULL);
  assign dst_data  = hold;
  assign dst_id    = hold_id;

endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb: transaction-level model plus directed literals.
// Model arbitration follows RR_ARB_EN the same way the build does.
module tb_reg_share_arb;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N*32-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            dst_valid;
  logic [31:0]     dst_data;
  logic [1:0]      dst_id;
  logic            dst_ready;

  logic [31:0] words [N];

  int checks = 0;
  int errors = 0;

  // Model state: is a word held, what is it, who sent it, next preferred source.
  logic        m_full;
  logic [31:0] m_data;
  int          m_id;
  int          m_ptr;

  reg_share_arb #(.NUM_REQ(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .dst_valid(dst_valid),
    .dst_data(dst_data),
    .dst_id(dst_id),
    .dst_ready(dst_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) src_data[32*i +: 32] = words[i];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Winner = valid source with smallest rotational distance from the
  // preferred index (fixed priority: preference is always index 0).
  function automatic int pick(input logic [N-1:0] v, input int pref);
    int best;
    int bd;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - pref + N) % N) < bd) begin
        bd = (i - pref + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic int model_winner();
`ifdef RR_ARB_EN
    return pick(src_valid, m_ptr);
`else
    return pick(src_valid, 0);
`endif
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w;
    logic [N-1:0] r;
    r = '0;
    w = model_winner();
    if (rst_n && (!m_full || dst_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_id   <= 0;
      m_ptr  <= 0;
    end else if (!m_full || dst_ready) begin
      if (model_winner() >= 0) begin
        m_full <= 1'b1;
        m_data <= words[model_winner()];
        m_id   <= model_winner();
        m_ptr  <= (model_winner() + 1) % N;
      end else begin
        m_full <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_src_ready", 32'(src_ready), 32'(model_ready()));
    check("m_dst_valid", 32'(dst_valid), 32'(m_full));
    check("m_dst_data", dst_data, m_data);
    check("m_dst_id", 32'(dst_id), 32'(m_id));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq [6];
    rst_n = 0;
    src_valid = '0;
    dst_ready = 0;
    for (int i = 0; i < N; i++) words[i] = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(dst_valid), 32'd0);
    check("rst_data", dst_data, 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    next();
    rst_n = 1;

    // Single transfer
    words[2] = 32'hDEADBEEF;
    src_valid = 4'b0100;
    dst_ready = 1;
    @(negedge clk);
    check("single_ready", 32'(src_ready), 32'h4);
    next();
    src_valid = '0;
    @(negedge clk);
    check("single_valid", 32'(dst_valid), 32'd1);
    check("single_data", dst_data, 32'hDEADBEEF);
    check("single_id", 32'(dst_id), 32'd2);
    next();
    @(negedge clk);
    check("single_drop", 32'(dst_valid), 32'd0);

    // Backpressure
    words[0] = 32'h12345678;
    src_valid = 4'b0001;
    next();
    words[1] = 32'hA5A50001;
    src_valid = 4'b0010;
    dst_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data", dst_data, 32'h12345678);
      check("bp_ready", 32'(src_ready), 32'd0);
      next();
    end
    dst_ready = 1;
    @(negedge clk);
    check("bp_release_ready", 32'(src_ready), 32'h2);
    next();
    src_valid = '0;
    @(negedge clk);
    check("bp_new_data", dst_data, 32'hA5A50001);
    check("bp_new_id", 32'(dst_id), 32'd1);
    next();

    // Arbitration with all sources requesting
    rst_n = 0;
    next();
    rst_n = 1;
    for (int i = 0; i < N; i++) words[i] = 32'h1000 + i;
    src_valid = 4'b1111;
`ifdef RR_ARB_EN
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
    seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    next();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arb_id", 32'(dst_id), 32'(seq[i]));
      check("arb_valid", 32'(dst_valid), 32'd1);
      next();
    end
    src_valid = 4'b1110;
    next();
`ifndef RR_ARB_EN
    @(negedge clk);
    check("fixed_next_id", 32'(dst_id), 32'd1);
`endif

    // Reset mid-operation
    words[0] = 32'hCAFEF00D;
    src_valid = 4'b0001;
    next();
    src_valid = 4'b0110;
    dst_ready = 0;
    @(negedge clk);
    check("pre_rst_data", dst_data, 32'hCAFEF00D);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("mid_rst_valid", 32'(dst_valid), 32'd0);
    check("mid_rst_data", dst_data, 32'd0);
    check("mid_rst_ready", 32'(src_ready), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1;
    dst_ready = 1;
    #1;
    check("post_rst_grant", 32'(src_ready), 32'h2);

    // Drain to empty
    next();
    src_valid = '0;
    @(negedge clk);
    check("drain_valid", 32'(dst_valid), 32'd1);
    next();
    @(negedge clk);
    check("drain_empty", 32'(dst_valid), 32'd0);
    check("drain_keep", dst_data, 32'h1001);
    words[3] = 32'h00000077;
    src_valid = 4'b1000;
    #1;
    check("drain_accept", 32'(src_ready), 32'h8);
    next();
    src_valid = '0;
    @(negedge clk);
    check("drain_reload", dst_data, 32'h77);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
